// File: rtl/vc_pop_arbiter_if.sv
// Bus between the VC pop arbiter and its surroundings: VC FIFO read side
// (empty, lookahead peek, registered read data, pop) and D0/D1 write side.
interface vc_pop_arbiter_if #(
    parameter int data_width = 6
);
    logic                  vc0_empty;
    logic                  vc1_empty;
    logic [data_width-1:0] vc0_peek;
    logic [data_width-1:0] vc1_peek;
    logic [data_width-1:0] vc0_rdata;
    logic [data_width-1:0] vc1_rdata;
    logic                  vc0_pop;
    logic                  vc1_pop;
    logic                  d0_almost_full;
    logic                  d1_almost_full;
    logic                  d0_push;
    logic                  d1_push;
    logic [data_width-1:0] data_out;

    // FIFO side: provides VC status and data, consumes pops and pushes.
    modport master (
        output vc0_empty, vc1_empty, vc0_peek, vc1_peek, vc0_rdata, vc1_rdata,
        output d0_almost_full, d1_almost_full,
        input  vc0_pop, vc1_pop, d0_push, d1_push, data_out
    );

    // Arbiter side.
    modport slave (
        input  vc0_empty, vc1_empty, vc0_peek, vc1_peek, vc0_rdata, vc1_rdata,
        input  d0_almost_full, d1_almost_full,
        output vc0_pop, vc1_pop, d0_push, d1_push, data_out
    );
endinterface

// File: rtl/vc_pop_arbiter.sv
// Pops VC0/VC1 with strict VC0 priority and routes each popped word to D0 or
// D1 by its MSB, one cycle after the pop, stalling on downstream almost-full.
module vc_pop_arbiter #(
    parameter int data_width = 6,
    parameter int cnt_width  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    vc_pop_arbiter_if.slave      bus,
    output logic [cnt_width-1:0] vc0_pop_cnt,
    output logic [cnt_width-1:0] vc1_pop_cnt,
    output logic                 idle_out,
    output logic                 active_out
);

    localparam int msb = data_width - 1;

    typedef enum logic [1:0] {
        ST_RESET,
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t               state_q, state_d;
    logic                 vc0_pop_q, vc0_pop_d;
    logic                 vc1_pop_q, vc1_pop_d;
    logic                 pop_dest_q, pop_dest_d;
    logic                 d0_push_q, d0_push_d;
    logic                 d1_push_q, d1_push_d;
    logic                 push_src_q, push_src_d;
    logic [cnt_width-1:0] cnt0_q, cnt0_d;
    logic [cnt_width-1:0] cnt1_q, cnt1_d;
    logic                 idle_q, idle_d;
    logic                 active_q, active_d;

    logic running;
    logic vc0_blocked;
    logic vc1_blocked;
    logic elig0;
    logic elig1;
    logic grant0;
    logic grant1;
    logic pop_pending;

    always_comb begin
        running     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        vc0_blocked = bus.vc0_peek[msb] ? bus.d1_almost_full : bus.d0_almost_full;
        vc1_blocked = bus.vc1_peek[msb] ? bus.d1_almost_full : bus.d0_almost_full;
        // The previous-cycle pop masks a VC because its flags are still stale.
        elig0       = running & init & ~bus.vc0_empty & ~vc0_blocked & ~vc0_pop_q;
        elig1       = running & init & ~bus.vc1_empty & ~vc1_blocked & ~vc1_pop_q;
        grant0      = elig0;
        grant1      = elig1 & ~elig0;
        pop_pending = vc0_pop_q | vc1_pop_q;
    end

    always_comb begin
        state_d    = state_q;
        vc0_pop_d  = 1'b0;
        vc1_pop_d  = 1'b0;
        pop_dest_d = 1'b0;
        d0_push_d  = 1'b0;
        d1_push_d  = 1'b0;
        push_src_d = 1'b0;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;

        case (state_q)
            ST_RESET: begin
                state_d = ST_INIT;
            end
            ST_INIT: begin
                cnt0_d = '0;
                cnt1_d = '0;
                if (init) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_ACTIVE: begin
                if (!init) begin
                    // Dropping init discards any in-flight push along with the counters.
                    state_d = ST_INIT;
                    cnt0_d  = '0;
                    cnt1_d  = '0;
                end else begin
                    vc0_pop_d  = grant0;
                    vc1_pop_d  = grant1;
                    pop_dest_d = grant1 ? bus.vc1_peek[msb] :
                                 (grant0 ? bus.vc0_peek[msb] : 1'b0);
                    d0_push_d  = pop_pending & ~pop_dest_q;
                    d1_push_d  = pop_pending & pop_dest_q;
                    push_src_d = vc1_pop_q;
                    cnt0_d     = cnt0_q + cnt_width'(grant0);
                    cnt1_d     = cnt1_q + cnt_width'(grant1);
                    if (grant0 || grant1) begin
                        state_d = ST_ACTIVE;
                    end else if (!pop_pending) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
            end
        endcase

        idle_d   = (state_d == ST_IDLE);
        active_d = (state_d == ST_ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            vc0_pop_q  <= 1'b0;
            vc1_pop_q  <= 1'b0;
            pop_dest_q <= 1'b0;
            d0_push_q  <= 1'b0;
            d1_push_q  <= 1'b0;
            push_src_q <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            idle_q     <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            vc0_pop_q  <= vc0_pop_d;
            vc1_pop_q  <= vc1_pop_d;
            pop_dest_q <= pop_dest_d;
            d0_push_q  <= d0_push_d;
            d1_push_q  <= d1_push_d;
            push_src_q <= push_src_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            idle_q     <= idle_d;
            active_q   <= active_d;
        end
    end

    // VC read data only becomes valid in the push cycle, so the word is steered
    // straight through rather than registered a second time.
    assign bus.data_out = (d0_push_q | d1_push_q) ?
                          (push_src_q ? bus.vc1_rdata : bus.vc0_rdata) : '0;

    assign bus.vc0_pop  = vc0_pop_q;
    assign bus.vc1_pop  = vc1_pop_q;
    assign bus.d0_push  = d0_push_q;
    assign bus.d1_push  = d1_push_q;
    assign vc0_pop_cnt  = cnt0_q;
    assign vc1_pop_cnt  = cnt1_q;
    assign idle_out     = idle_q;
    assign active_out   = active_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Directed bench for vc_pop_arbiter: behavioural VC FIFOs feed the DUT and a
// scoreboard monitor checks every D0/D1 push against queued expectations.
module tb_vc_pop_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       init;
    logic [7:0] vc0_pop_cnt;
    logic [7:0] vc1_pop_cnt;
    logic       idle_out;
    logic       active_out;

    int checks = 0;
    int errors = 0;

    vc_pop_arbiter_if #(.data_width(6)) bus ();

    vc_pop_arbiter #(.data_width(6), .cnt_width(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .init        (init),
        .bus         (bus),
        .vc0_pop_cnt (vc0_pop_cnt),
        .vc1_pop_cnt (vc1_pop_cnt),
        .idle_out    (idle_out),
        .active_out  (active_out)
    );

    always #5 clk = ~clk;

    // Behavioural VC FIFOs: peek/empty refresh and rdata appear after the pop edge.
    logic [5:0] vc0_mem [0:511];
    logic [5:0] vc1_mem [0:511];
    int         vc0_rd = 0;
    int         vc1_rd = 0;
    int         vc0_wr = 0;
    int         vc1_wr = 0;

    assign bus.vc0_empty = (vc0_rd == vc0_wr);
    assign bus.vc1_empty = (vc1_rd == vc1_wr);
    assign bus.vc0_peek  = vc0_mem[vc0_rd];
    assign bus.vc1_peek  = vc1_mem[vc1_rd];

    always @(posedge clk) begin
        if (bus.vc0_pop) begin
            bus.vc0_rdata <= vc0_mem[vc0_rd];
            vc0_rd        <= vc0_rd + 1;
        end
        if (bus.vc1_pop) begin
            bus.vc1_rdata <= vc1_mem[vc1_rd];
            vc1_rd        <= vc1_rd + 1;
        end
    end

    logic [6:0] exp_q [$];

    task automatic check_output(input string name, input logic [31:0] got,
                                input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
        end
    endtask

    task automatic apply_stimulus(input int vc, input logic [5:0] word,
                                  input logic [6:0] want, input bit track);
        if (vc == 0) begin
            vc0_mem[vc0_wr] = word;
            vc0_wr++;
        end else begin
            vc1_mem[vc1_wr] = word;
            vc1_wr++;
        end
        if (track) exp_q.push_back(want);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && !idle_out; i++) @(negedge clk);
        check_output("idle_wait", idle_out, 1);
    endtask

    // Scoreboard monitor plus pop invariants, sampled on the falling edge.
    logic prev0 = 1'b0;
    logic prev1 = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            prev0 = 1'b0;
            prev1 = 1'b0;
        end else begin
            check_output("pop_onehot", bus.vc0_pop & bus.vc1_pop, 0);
            check_output("vc0_back_to_back", prev0 & bus.vc0_pop, 0);
            check_output("vc1_back_to_back", prev1 & bus.vc1_pop, 0);
            if (bus.d0_push || bus.d1_push) begin
                check_output("push_onehot", bus.d0_push & bus.d1_push, 0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_push: got dest %0d data 0x%0h, expected no push",
                             bus.d1_push, bus.data_out);
                end else begin
                    check_output("push_word", {bus.d1_push, bus.data_out}, exp_q.pop_front());
                end
            end else begin
                check_output("data_out_idle", bus.data_out, 0);
            end
            prev0 = bus.vc0_pop;
            prev1 = bus.vc1_pop;
        end
    end

    logic [7:0] pat_pop0;
    logic [7:0] pat_pop1;
    logic [7:0] pat_d0;
    logic [7:0] pat_d1;
    logic [7:0] wv;

    initial begin
        reset              = 1'b1;
        init               = 1'b0;
        bus.d0_almost_full = 1'b0;
        bus.d1_almost_full = 1'b0;
        bus.vc0_rdata      = '0;
        bus.vc1_rdata      = '0;

        #2;
        check_output("rst_vc0_pop", bus.vc0_pop, 0);
        check_output("rst_vc1_pop", bus.vc1_pop, 0);
        check_output("rst_push", {bus.d0_push, bus.d1_push}, 0);
        check_output("rst_data_out", bus.data_out, 0);
        check_output("rst_counters", {vc0_pop_cnt, vc1_pop_cnt}, 0);
        check_output("rst_state", {idle_out, active_out}, 0);

        apply_stimulus(0, 6'h05, 7'h05, 1);
        apply_stimulus(0, 6'h21, 7'h61, 1);
        apply_stimulus(0, 6'h0A, 7'h0A, 1);
        apply_stimulus(0, 6'h3F, 7'h7F, 1);

        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_output("init_no_pop", bus.vc0_pop, 0);
            check_output("init_state", {idle_out, active_out}, 0);
        end

        init = 1'b1;
        @(negedge clk);
        check_output("init_to_idle", idle_out, 1);

        // Single VC0 stream: pops every other cycle, pushes one cycle later.
        pat_pop0 = 8'b0101_0101;
        pat_d0   = 8'b0010_0010;
        pat_d1   = 8'b1000_1000;
        @(negedge clk);
        check_output("stream_active", active_out, 1);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            check_output("stream_vc0_pop", bus.vc0_pop, pat_pop0[k]);
            check_output("stream_d0_push", bus.d0_push, pat_d0[k]);
            check_output("stream_d1_push", bus.d1_push, pat_d1[k]);
        end
        @(negedge clk);
        check_output("stream_cnt0", vc0_pop_cnt, 4);
        wait_idle();

        // Both VCs loaded, all to D0: VC0/VC1 alternate.
        apply_stimulus(0, 6'h01, 7'h01, 1);
        apply_stimulus(0, 6'h02, 7'h11, 0);
        apply_stimulus(0, 6'h03, 7'h00, 0);
        apply_stimulus(1, 6'h11, 7'h00, 0);
        apply_stimulus(1, 6'h12, 7'h00, 0);
        apply_stimulus(1, 6'h13, 7'h00, 0);
        exp_q.push_back(7'h11);
        exp_q.push_back(7'h02);
        exp_q.push_back(7'h12);
        exp_q.push_back(7'h03);
        exp_q.push_back(7'h13);
        pat_pop0 = 8'b0001_0101;
        pat_pop1 = 8'b0010_1010;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check_output("ilv_vc0_pop", bus.vc0_pop, pat_pop0[k]);
            check_output("ilv_vc1_pop", bus.vc1_pop, pat_pop1[k]);
        end
        wait_idle();
        check_output("ilv_cnt0", vc0_pop_cnt, 7);
        check_output("ilv_cnt1", vc1_pop_cnt, 3);

        // D1 backpressure blocks the VC0 head (dest D1) but not VC1 (dest D0).
        bus.d1_almost_full = 1'b1;
        apply_stimulus(0, 6'h2A, 7'h00, 0);
        apply_stimulus(1, 6'h03, 7'h03, 1);
        exp_q.push_back(7'h6A);
        @(negedge clk);
        check_output("bp_vc1_pop", bus.vc1_pop, 1);
        check_output("bp_vc0_held", bus.vc0_pop, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_output("bp_vc0_held", bus.vc0_pop, 0);
        end
        bus.d1_almost_full = 1'b0;
        @(negedge clk);
        check_output("bp_release_pop", bus.vc0_pop, 1);
        wait_idle();
        check_output("bp_cnt0", vc0_pop_cnt, 8);
        check_output("bp_cnt1", vc1_pop_cnt, 4);

        // Dropping init during a pop discards the push and clears the counters.
        apply_stimulus(0, 6'h07, 7'h00, 0);
        @(negedge clk);
        check_output("drop_pop", bus.vc0_pop, 1);
        init = 1'b0;
        @(negedge clk);
        check_output("drop_no_push", {bus.d0_push, bus.d1_push}, 0);
        check_output("drop_counters", {vc0_pop_cnt, vc1_pop_cnt}, 0);
        check_output("drop_state", {idle_out, active_out}, 0);
        @(negedge clk);
        check_output("drop_no_push_late", {bus.d0_push, bus.d1_push}, 0);
        init = 1'b1;
        @(negedge clk);
        check_output("reinit_idle", idle_out, 1);

        // 256 VC0 pops wrap the 8-bit counter back to zero.
        for (int i = 0; i < 256; i++) begin
            wv = 8'(i);
            apply_stimulus(0, wv[5:0], {wv[5], wv[5:0]}, 1);
        end
        for (int i = 0; i < 700 && exp_q.size() != 0; i++) @(negedge clk);
        check_output("wrap_drained", exp_q.size(), 0);
        wait_idle();
        check_output("wrap_cnt0", vc0_pop_cnt, 0);
        check_output("wrap_cnt1", vc1_pop_cnt, 0);

        // Asynchronous reset between edges while a push is pending.
        apply_stimulus(0, 6'h09, 7'h00, 0);
        @(negedge clk);
        check_output("areset_pop", bus.vc0_pop, 1);
        check_output("areset_cnt_before", vc0_pop_cnt, 1);
        #2;
        reset = 1'b1;
        #1;
        check_output("areset_pop_clear", bus.vc0_pop, 0);
        check_output("areset_cnt_clear", vc0_pop_cnt, 0);
        check_output("areset_state", {idle_out, active_out}, 0);
        @(negedge clk);
        check_output("areset_no_push", {bus.d0_push, bus.d1_push}, 0);
        check_output("areset_data_out", bus.data_out, 0);
        check_output("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
